// File: rtl/blob_pkg.sv
// Shared types and constants for the blob bounding-box tracker.
package blob_pkg;
  localparam int RGB_W      = 10;
  localparam int GRAY_W     = 8;
  localparam int COORD_W    = 10;
  localparam int CNT_W      = 19;
  localparam int K_R        = 77;
  localparam int K_G        = 150;
  localparam int K_B        = 29;
  localparam int GRAY_SHIFT = 10;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SCAN, S_DONE} state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
    logic [CNT_W-1:0]   cnt;
  } acc_t;

  localparam acc_t ACC_CLR = '{x_min: {COORD_W{1'b1}}, x_max: '0,
                               y_min: {COORD_W{1'b1}}, y_max: '0, cnt: '0};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/rgb_to_gray.sv
// Two-stage RGB->gray: stage 1 registers the weighted products, stage 2 the scaled sum.
module rgb_to_gray import blob_pkg::*; (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [RGB_W-1:0]  i_r,
  input  logic [RGB_W-1:0]  i_g,
  input  logic [RGB_W-1:0]  i_b,
  output logic [GRAY_W-1:0] o_gray,
  output logic              o_valid
);
  localparam int STAGES = 2;
  localparam int PROD_W = 18;  // 256*1023 fits, so the sum never overflows

  logic [STAGES:1]   vld_pipe_q;
  logic [PROD_W-1:0] pr_q, pg_q, pb_q;
  logic [PROD_W-1:0] sum;

  assign sum = pr_q + pg_q + pb_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_pipe_q <= '0;
      pr_q       <= '0;
      pg_q       <= '0;
      pb_q       <= '0;
      o_gray     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], i_valid};
      pr_q       <= PROD_W'(i_r) * PROD_W'(K_R);
      pg_q       <= PROD_W'(i_g) * PROD_W'(K_G);
      pb_q       <= PROD_W'(i_b) * PROD_W'(K_B);
      o_gray     <= GRAY_W'(sum >> GRAY_SHIFT);
    end
  end

  assign o_valid = vld_pipe_q[STAGES];
endmodule

// File: rtl/blob_bbox_tracker.sv
// Thresholds the gray stream and tracks the bright-pixel bounding box per frame.
// Optional BLOB_SHORT_FRAME_CHECK_EN: a frame start mid-scan aborts and restarts the scan.
module blob_bbox_tracker import blob_pkg::*; #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int THRESH    = 200,
  parameter int MIN_COUNT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_frame_start,
  input  logic               i_valid,
  input  logic [RGB_W-1:0]   i_r,
  input  logic [RGB_W-1:0]   i_g,
  input  logic [RGB_W-1:0]   i_b,
  output logic [GRAY_W-1:0]  o_gray,
  output logic               o_gray_valid,
  output logic [COORD_W-1:0] o_x_min,
  output logic [COORD_W-1:0] o_x_max,
  output logic [COORD_W-1:0] o_y_min,
  output logic [COORD_W-1:0] o_y_max,
  output logic               o_bbox_valid,
  output logic [CNT_W-1:0]   o_pix_count,
  output logic               o_blob_end,
  output logic               o_frame_err
);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  state_e                    state_q;
  logic [COORD_W-1:0]        x_q, y_q;
  logic                      tail_q;
  logic [2:1]                sc_q, last_q;
  logic [2:1][COORD_W-1:0]   xp_q, yp_q;
  acc_t                      acc_q, acc_d, res_q;
  logic                      bbox_vld_q, blob_end_q;
  logic                      abort, restart, take, px_last, hit, fin;
  logic [COORD_W-1:0]        px_x, px_y;

  rgb_to_gray u_gray (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_r     (i_r),
    .i_g     (i_g),
    .i_b     (i_b),
    .o_gray  (o_gray),
    .o_valid (o_gray_valid)
  );

`ifdef BLOB_SHORT_FRAME_CHECK_EN
  assign abort = (state_q == S_SCAN) && i_frame_start && !tail_q;
`else
  assign abort = 1'b0;
`endif

  // tail_q: last pixel already taken; further input pixels belong to no frame
  assign restart = ((state_q == S_ARM) && i_frame_start) || abort;
  assign take    = i_valid && (restart || ((state_q == S_SCAN) && !tail_q));
  assign px_x    = restart ? '0 : x_q;
  assign px_y    = restart ? '0 : y_q;
  assign px_last = (px_x == X_LAST) && (px_y == Y_LAST);
  assign hit     = sc_q[2] && (o_gray >= GRAY_W'(THRESH));
  assign fin     = sc_q[2] && last_q[2];

  // Includes the pixel now leaving the gray pipe, so DONE sees the final pixel
  always_comb begin
    acc_d = acc_q;
    if (hit) begin
      if (xp_q[2] < acc_q.x_min) acc_d.x_min = xp_q[2];
      if (xp_q[2] > acc_q.x_max) acc_d.x_max = xp_q[2];
      if (yp_q[2] < acc_q.y_min) acc_d.y_min = yp_q[2];
      if (yp_q[2] > acc_q.y_max) acc_d.y_max = yp_q[2];
      acc_d.cnt = sat_inc(acc_q.cnt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      tail_q     <= 1'b0;
      sc_q       <= '0;
      last_q     <= '0;
      xp_q       <= '0;
      yp_q       <= '0;
      acc_q      <= ACC_CLR;
      res_q      <= '0;
      bbox_vld_q <= 1'b0;
      blob_end_q <= 1'b0;
    end else begin
      // an abort drops the old frame's pixel still in flight
      sc_q       <= {sc_q[1] && !abort, take};
      last_q     <= {last_q[1], take && px_last};
      xp_q       <= {xp_q[1], px_x};
      yp_q       <= {yp_q[1], px_y};
      blob_end_q <= 1'b0;
      if (restart) begin
        x_q    <= '0;
        y_q    <= '0;
        tail_q <= 1'b0;
      end
      if (take) begin
        x_q <= (px_x == X_LAST) ? '0 : px_x + 1'b1;
        y_q <= (px_x == X_LAST) ? px_y + 1'b1 : px_y;
        if (px_last) tail_q <= 1'b1;
      end
      acc_q <= restart ? ACC_CLR : acc_d;
      case (state_q)
        S_IDLE: if (i_start) state_q <= S_ARM;
        S_ARM:  if (i_frame_start) state_q <= S_SCAN;
        S_SCAN: if (fin) begin
          state_q    <= S_DONE;
          blob_end_q <= 1'b1;
          bbox_vld_q <= (acc_d.cnt >= CNT_W'(MIN_COUNT));
          res_q      <= '0;
          res_q.cnt  <= acc_d.cnt;
          if (acc_d.cnt >= CNT_W'(MIN_COUNT)) res_q <= acc_d;
        end
        S_DONE:  state_q <= i_start ? S_ARM : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef BLOB_SHORT_FRAME_CHECK_EN
  logic err_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   err_q <= 1'b0;
    else if (abort) err_q <= 1'b1;
  end
  assign o_frame_err = err_q;
`else
  assign o_frame_err = 1'b0;
`endif

  assign o_x_min      = res_q.x_min;
  assign o_x_max      = res_q.x_max;
  assign o_y_min      = res_q.y_min;
  assign o_y_max      = res_q.y_max;
  assign o_pix_count  = res_q.cnt;
  assign o_bbox_valid = bbox_vld_q;
  assign o_blob_end   = blob_end_q;
endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Scoreboard bench for blob_bbox_tracker on a reduced 112x56 frame.
module tb_blob_bbox_tracker;
  localparam int H = 112;
  localparam int V = 56;
  localparam int FRAME = H * V;

  typedef struct {int g; int due;} gexp_t;
  typedef struct {int xmn; int xmx; int ymn; int ymx; int cnt; int bv; int due;} bexp_t;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, fs = 1'b0, vld = 1'b0;
  logic [9:0] r = '0, g = '0, b = '0;
  logic [7:0] o_gray;
  logic       o_gray_valid, o_bbox_valid, o_blob_end, o_frame_err;
  logic [9:0] o_x_min, o_x_max, o_y_min, o_y_max;
  logic [18:0] o_pix_count;

  int cyc = 0, n_chk = 0, n_pass = 0;
  gexp_t gq[$];
  bexp_t bq[$];
  gexp_t ge;
  bexp_t be;

  blob_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .THRESH(200), .MIN_COUNT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_start(fs), .i_valid(vld),
    .i_r(r), .i_g(g), .i_b(b), .o_gray(o_gray), .o_gray_valid(o_gray_valid),
    .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min), .o_y_max(o_y_max),
    .o_bbox_valid(o_bbox_valid), .o_pix_count(o_pix_count),
    .o_blob_end(o_blob_end), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // gray scoreboard: every accepted pixel must show up two cycles later, in order
  always @(negedge clk) begin
    if (o_gray_valid === 1'b1) begin
      if (gq.size() == 0) chk("gray_unexpected", 1, 0);
      else begin
        ge = gq.pop_front();
        chk("gray", o_gray, ge.g);
        chk("gray_latency", cyc, ge.due);
      end
    end
  end

  always @(negedge clk) begin
    if (o_blob_end === 1'b1) begin
      if (bq.size() == 0) chk("blob_end_unexpected", 1, 0);
      else begin
        be = bq.pop_front();
        chk("blob_end_time", cyc, be.due);
        chk("x_min", o_x_min, be.xmn);
        chk("x_max", o_x_max, be.xmx);
        chk("y_min", o_y_min, be.ymn);
        chk("y_max", o_y_max, be.ymx);
        chk("pix_count", o_pix_count, be.cnt);
        chk("bbox_valid", o_bbox_valid, be.bv);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, checks %0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic drive_px(input bit v, input bit f, input bit bright);
    gexp_t e;
    r = bright ? 10'($urandom_range(1023, 850)) : 10'($urandom_range(700, 0));
    g = bright ? 10'($urandom_range(1023, 850)) : 10'($urandom_range(700, 0));
    b = bright ? 10'($urandom_range(1023, 850)) : 10'($urandom_range(700, 0));
    vld = v;
    fs  = f;
    if (v) begin
      e.g   = ((77 * int'(r) + 150 * int'(g) + 29 * int'(b)) >> 10) & 255;
      e.due = cyc + 2;
      gq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_px(0, 0, 0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_blob_end"}, o_blob_end, 0);
    chk({pfx, "_pix_count"}, o_pix_count, 0);
    chk({pfx, "_x_min"}, o_x_min, 0);
    chk({pfx, "_x_max"}, o_x_max, 0);
    chk({pfx, "_y_min"}, o_y_min, 0);
    chk({pfx, "_y_max"}, o_y_max, 0);
    chk({pfx, "_bbox_valid"}, o_bbox_valid, 0);
    chk({pfx, "_frame_err"}, o_frame_err, 0);
    chk({pfx, "_gray_valid"}, o_gray_valid, 0);
    chk({pfx, "_gray"}, o_gray, 0);
  endtask

  task automatic do_reset_mid();
    rst_n = 1'b0; vld = 1'b0; fs = 1'b0;
    @(posedge clk); #1;
    gq.delete();
    check_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic bit bright_at(input int mode, input int x, input int y);
    case (mode)
      0: return 1'b1;
      1: return (x >= 100 && x <= 103 && y >= 50 && y <= 53);
      2: return (y == 10 && x < 15);
      default: return 1'b0;
    endcase
  endfunction

  // fs2: extra frame-start index; rst_y / drop_y: line at which to reset / drop start
  task automatic run_frame(input int mode, input int fs2, input int rst_y,
                           input int drop_y, input bit exp_end);
    int origin, idx, rel, x, y, xmn, xmx, ymn, ymx, cnt;
    bit br;
    bexp_t e;
    origin = 0; idx = 0;
    xmn = 1023; xmx = 0; ymn = 1023; ymx = 0; cnt = 0;
    while (idx < origin + FRAME) begin
      rel = idx - origin;
      if (rst_y >= 0 && rel == rst_y * H) begin
        do_reset_mid();
        return;
      end
      if (drop_y >= 0 && rel == drop_y * H) start = 1'b0;
      if (idx % 53 == 52) drive_px(0, 0, 0);
`ifdef BLOB_SHORT_FRAME_CHECK_EN
      if (idx == fs2) begin
        origin = idx; rel = 0;
        xmn = 1023; xmx = 0; ymn = 1023; ymx = 0; cnt = 0;
      end
`endif
      x = rel % H; y = rel / H;
      br = bright_at(mode, x, y);
      if (br) begin
        if (x < xmn) xmn = x;
        if (x > xmx) xmx = x;
        if (y < ymn) ymn = y;
        if (y > ymx) ymx = y;
        cnt++;
      end
      if (rel == FRAME - 1 && exp_end) begin
        e.bv  = (cnt >= 16) ? 1 : 0;
        e.xmn = e.bv ? xmn : 0;
        e.xmx = e.bv ? xmx : 0;
        e.ymn = e.bv ? ymn : 0;
        e.ymx = e.bv ? ymx : 0;
        e.cnt = cnt;
        e.due = cyc + 3;
        bq.push_back(e);
      end
      drive_px(1, (idx == 0) || (idx == fs2), br);
      idx++;
    end
    idle(8);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // IDLE: gray still produced, frame starts ignored
    for (int i = 0; i < 20; i++) drive_px(1, (i % 7) == 0, i[0]);
    idle(4);

    start = 1'b1;
    idle(3);
    run_frame(0, -1, -1, -1, 1);
    run_frame(1, -1, -1, -1, 1);
    run_frame(2, -1, -1, -1, 1);
    idle(20);
    chk("hold_pix_count", o_pix_count, 15);
    chk("hold_bbox_valid", o_bbox_valid, 0);
    chk("frame_err_before_abort", o_frame_err, 0);

    run_frame(1, 1000, -1, -1, 1);
`ifdef BLOB_SHORT_FRAME_CHECK_EN
    chk("frame_err_after_abort", o_frame_err, 1);
`else
    chk("frame_err_after_abort", o_frame_err, 0);
`endif

    run_frame(1, -1, -1, 30, 1);
    run_frame(0, -1, -1, -1, 0);
    chk("hold_x_min", o_x_min, 100);
    chk("hold_pix_count2", o_pix_count, 16);
    chk("hold_bbox_valid2", o_bbox_valid, 1);

    start = 1'b1;
    idle(3);
    run_frame(0, -1, 40, -1, 0);
    idle(3);
    run_frame(1, -1, -1, -1, 1);

    idle(10);
    chk("gray_queue_drained", gq.size(), 0);
    chk("blob_queue_drained", bq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/blob_bbox_tracker.md
BLOB_BBOX_TRACKER -- requirements
Module: blob_bbox_tracker

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameter THRESH, default 200, 8-bit gray level; a pixel counts as bright when gray >= THRESH.
REQ-004 SHALL have parameter MIN_COUNT, default 16, minimum bright pixels for a valid blob.
REQ-005 SHALL have port i_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port i_start  in  1  level from the sync controller's grayscale-start output; arms scanning.
REQ-008 SHALL have port i_frame_start  in  1  one-cycle pulse at the first active pixel slot of a frame.
REQ-009 SHALL have port i_valid  in  1  pixel strobe; i_r/i_g/i_b are sampled only when high.
REQ-010 SHALL have ports i_r, i_g, i_b  in  10 each  camera RGB.
REQ-011 SHALL have ports o_gray  out  8  and o_gray_valid  out  1  for the grayscale pixel stream.
REQ-012 SHALL have ports o_x_min, o_x_max, o_y_min, o_y_max  out  10 each  for the bounding box, plus o_bbox_valid  out  1.
REQ-013 SHALL have port o_pix_count  out  19  bright pixel count of the last completed frame.
REQ-014 SHALL have ports o_blob_end  out  1  completion pulse, consumed by the sync controller, and o_frame_err  out  1  sticky.

Function
REQ-015 SHALL compute gray = (77*R + 150*G + 29*B) >> 10, truncated to 8 bits, in a 2-stage pipeline: a pixel sampled in cycle T appears on o_gray with o_gray_valid in cycle T+2.
REQ-016 SHALL implement FSM IDLE, ARM, SCAN, DONE with the following transitions: IDLE->ARM when i_start=1; ARM->SCAN on i_frame_start; SCAN->DONE after the pixel with x=H_ACTIVE-1, y=V_ACTIVE-1 leaves the gray pipeline; DONE->ARM if i_start=1, else DONE->IDLE.
REQ-017 SHALL treat the i_frame_start cycle as a pixel slot: the pixel valid in that same cycle is x=0,y=0.
REQ-018 SHALL keep 10-bit x and y counters advanced only on i_valid in SCAN, with x wrapping at H_ACTIVE-1 to 0 and y incrementing on that wrap.
REQ-019 SHALL, on each bright gray pixel in SCAN, update the running min/max x/y and increment the bright count; the count saturates at 2^19-1.
REQ-020 SHALL, in DONE, register the results to the outputs and pulse o_blob_end for exactly one cycle, 3 cycles after the last pixel's i_valid.
REQ-021 SHALL drive o_bbox_valid=1 only when count >= MIN_COUNT; otherwise the box outputs SHALL be 0 and o_bbox_valid=0; o_pix_count SHALL always carry the count.
REQ-022 SHALL hold all result outputs stable from DONE until the next DONE.
REQ-023 SHALL ignore i_start deassertion during SCAN: the frame completes.
REQ-024 SHALL ignore i_valid and i_frame_start in IDLE; o_gray is still produced in every state.
REQ-025 SHALL, if i_frame_start and DONE coincide with i_start=1, go to ARM and not to SCAN; that frame is skipped.
REQ-026 SHALL clear the accumulators (min=1023, max=0, count=0) on every entry to SCAN.

Reset
REQ-027 SHALL on i_rst_n=0 at a clock edge: state IDLE, counters and accumulators cleared, all outputs 0, o_frame_err cleared, pipeline valids 0.
REQ-028 SHALL abandon a scan on reset mid-frame with no o_blob_end pulse.

Configuration
REQ-029 SHALL, with BLOB_SHORT_FRAME_CHECK_EN defined, treat i_frame_start in SCAN before the last pixel as an abort: set o_frame_err, clear the accumulators, and restart SCAN at x=0,y=0 with that pixel.
REQ-030 SHALL, without BLOB_SHORT_FRAME_CHECK_EN, ignore i_frame_start in SCAN and tie o_frame_err to 0.

Structure
REQ-031 SHALL place the FSM state enum, gray coefficients (77/150/29), coordinate width (10) and count width (19) in shared package blob_pkg.
REQ-032 SHALL implement the grayscale pipeline as sub-module rgb_to_gray (2 stages, valid passthrough).

Verification
REQ-033 The bench SHALL drive all pixels R=G=B=1023: o_gray=255 at T+2, and o_blob_end with box 0/639/0/479, count 307200, valid=1.
REQ-034 The bench SHALL drive a bright 4x4 square at x=100..103, y=50..53 on black: box 100/103/50/53, count 16, o_bbox_valid=1.
REQ-035 The bench SHALL drive 15 bright pixels only: o_pix_count=15, o_bbox_valid=0, box outputs 0.
REQ-036 The bench SHALL pulse i_frame_start at pixel 1000 of a scan with the macro defined: o_frame_err=1, no o_blob_end, and the next full frame reports correctly; without the macro, the frame completes normally.
REQ-037 The bench SHALL drop i_start mid-SCAN: o_blob_end still pulses once, then the FSM goes to IDLE and later frames are ignored.
REQ-038 The bench SHALL assert reset at y=200: outputs 0, no pulse; re-arming then scanning yields a correct result.
